// File: rtl/alu_arbiter.sv
// Two-requester front end for one shared ALU: round-robin grant, registered
// operand drive, fixed-latency capture and a held response per owner.
module alu_arbiter #(
  parameter int ALU_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_0,
  input  logic        req_valid_1,
  output logic        req_ready_0,
  output logic        req_ready_1,
  input  logic [3:0]  req_ctrl_0,
  input  logic [3:0]  req_ctrl_1,
  input  logic [31:0] req_a_0,
  input  logic [31:0] req_b_0,
  input  logic [31:0] req_a_1,
  input  logic [31:0] req_b_1,
  output logic        resp_valid_0,
  output logic        resp_valid_1,
  input  logic        resp_ready_0,
  input  logic        resp_ready_1,
  output logic [31:0] resp_result,
  output logic        resp_overflow,
  output logic        resp_zero,
  output logic [3:0]  alu_control,
  output logic [31:0] alu_oper1,
  output logic [31:0] alu_oper2,
  input  logic [31:0] alu_result,
  input  logic        alu_overflow,
  input  logic        alu_zero,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] LAT_M1 = 4'(ALU_LAT - 1);

  state_t      state_q, state_d;
  logic        prio_q, prio_d;
  logic        owner_q, owner_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  alu_control_q, alu_control_d;
  logic [31:0] alu_oper1_q, alu_oper1_d;
  logic [31:0] alu_oper2_q, alu_oper2_d;
  logic [31:0] resp_result_q, resp_result_d;
  logic        resp_overflow_q, resp_overflow_d;
  logic        resp_zero_q, resp_zero_d;
  logic        grant_1;
  logic        owner_ready;

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; ready never waits on anything the requester does after valid.
  assign grant_1     = req_valid_1 && (!req_valid_0 || prio_q);
  assign req_ready_0 = rst_n && (state_q == IDLE) && req_valid_0 && !grant_1;
  assign req_ready_1 = rst_n && (state_q == IDLE) && grant_1;

  assign owner_ready = owner_q ? resp_ready_1 : resp_ready_0;

  assign resp_valid_0  = (state_q == RESP) && !owner_q;
  assign resp_valid_1  = (state_q == RESP) && owner_q;
  assign resp_result   = resp_result_q;
  assign resp_overflow = resp_overflow_q;
  assign resp_zero     = resp_zero_q;
  assign alu_control   = alu_control_q;
  assign alu_oper1     = alu_oper1_q;
  assign alu_oper2     = alu_oper2_q;
  assign dbg_state_o   = state_q;

  always_comb begin
    state_d         = state_q;
    prio_d          = prio_q;
    owner_d         = owner_q;
    cnt_d           = cnt_q;
    alu_control_d   = alu_control_q;
    alu_oper1_d     = alu_oper1_q;
    alu_oper2_d     = alu_oper2_q;
    resp_result_d   = resp_result_q;
    resp_overflow_d = resp_overflow_q;
    resp_zero_d     = resp_zero_q;
    case (state_q)
      IDLE: begin
        if (req_valid_0 || req_valid_1) begin
          state_d       = EXEC;
          owner_d       = grant_1;
          cnt_d         = LAT_M1;
          alu_control_d = grant_1 ? req_ctrl_1 : req_ctrl_0;
          alu_oper1_d   = grant_1 ? req_a_1 : req_a_0;
          alu_oper2_d   = grant_1 ? req_b_1 : req_b_0;
        end
      end
      EXEC: begin
        // Operands have been stable for ALU_LAT cycles when the count hits 0.
        if (cnt_q == 4'd0) begin
          resp_result_d   = alu_result;
          resp_overflow_d = alu_overflow;
          resp_zero_d     = alu_zero;
          state_d         = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (owner_ready) begin
          state_d = IDLE;
          prio_d  = ~owner_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      prio_q          <= 1'b0;
      owner_q         <= 1'b0;
      cnt_q           <= 4'd0;
      alu_control_q   <= 4'd0;
      alu_oper1_q     <= 32'd0;
      alu_oper2_q     <= 32'd0;
      resp_result_q   <= 32'd0;
      resp_overflow_q <= 1'b0;
      resp_zero_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      prio_q          <= prio_d;
      owner_q         <= owner_d;
      cnt_q           <= cnt_d;
      alu_control_q   <= alu_control_d;
      alu_oper1_q     <= alu_oper1_d;
      alu_oper2_q     <= alu_oper2_d;
      resp_result_q   <= resp_result_d;
      resp_overflow_q <= resp_overflow_d;
      resp_zero_q     <= resp_zero_d;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU, round-robin reference model,
// expected-response queue and a negedge monitor.
module tb_alu_arbiter;
  localparam int ALU_LAT = 1;
  localparam int W = 35;  // {owner, overflow, zero, result}

  logic clk = 1'b0;
  logic rst_n;
  logic req_valid_0, req_valid_1, req_ready_0, req_ready_1;
  logic [3:0] req_ctrl_0, req_ctrl_1;
  logic [31:0] req_a_0, req_b_0, req_a_1, req_b_1;
  logic resp_valid_0, resp_valid_1, resp_ready_0, resp_ready_1;
  logic [31:0] resp_result;
  logic resp_overflow, resp_zero;
  logic [3:0] alu_control;
  logic [31:0] alu_oper1, alu_oper2, alu_result;
  logic alu_overflow, alu_zero;
  logic [1:0] dbg_state_o;

  alu_arbiter #(.ALU_LAT(ALU_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
    .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
    .req_ctrl_0(req_ctrl_0), .req_ctrl_1(req_ctrl_1),
    .req_a_0(req_a_0), .req_b_0(req_b_0), .req_a_1(req_a_1), .req_b_1(req_b_1),
    .resp_valid_0(resp_valid_0), .resp_valid_1(resp_valid_1),
    .resp_ready_0(resp_ready_0), .resp_ready_1(resp_ready_1),
    .resp_result(resp_result), .resp_overflow(resp_overflow), .resp_zero(resp_zero),
    .alu_control(alu_control), .alu_oper1(alu_oper1), .alu_oper2(alu_oper2),
    .alu_result(alu_result), .alu_overflow(alu_overflow), .alu_zero(alu_zero),
    .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- behavioural ALU ----------------
  function automatic logic [33:0] alu_fn(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic v;
    v = 1'b0;
    case (c)
      4'd0: begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); end
      4'd1: begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = a << b[4:0];
      default: r = a;
    endcase
    return {v, (r == 32'd0), r};
  endfunction

  assign {alu_overflow, alu_zero, alu_result} = alu_fn(alu_control, alu_oper1, alu_oper2);

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int grant_log[$];
  int checks = 0;
  int errors = 0;
  logic m_busy = 1'b0;
  logic m_prio = 1'b0;
  int acc_cyc = 0;
  logic resp_seen = 1'b0;
  logic rnd_on = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin : monitor
    logic g, eg, eo;
    logic [W-1:0] e;
    if (rst_n) begin
      if (req_ready_0 || req_ready_1) begin
        check("ready_onehot", {req_ready_1, req_ready_0} == 2'b11, 1'b0);
        check("ready_without_valid", (req_ready_0 && !req_valid_0) || (req_ready_1 && !req_valid_1), 1'b0);
        check("accept_while_busy", m_busy, 1'b0);
        g  = req_ready_1;
        eg = (req_valid_0 && req_valid_1) ? m_prio : req_valid_1;
        check("grant", g, eg);
        exp_q.push_back({g, g ? alu_fn(req_ctrl_1, req_a_1, req_b_1)
                              : alu_fn(req_ctrl_0, req_a_0, req_b_0)});
        grant_log.push_back(int'(g));
        m_busy    = 1'b1;
        acc_cyc   = cyc;
        resp_seen = 1'b0;
      end else if (!m_busy && (req_valid_0 || req_valid_1)) begin
        check("idle_grant", 1'b0, 1'b1);
      end
      if (resp_valid_0 || resp_valid_1) begin
        check("resp_onehot", resp_valid_0 && resp_valid_1, 1'b0);
        check("resp_pending", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          e  = exp_q[0];
          eo = e[34];
          check("resp_owner", resp_valid_1, eo);
          check("resp_result", resp_result, e[31:0]);
          check("resp_zero", resp_zero, e[32]);
          check("resp_overflow", resp_overflow, e[33]);
          if (!resp_seen) begin
            check("latency", 64'(cyc - acc_cyc), 64'(ALU_LAT + 1));
            resp_seen = 1'b1;
          end
          if (eo ? resp_ready_1 : resp_ready_0) begin
            void'(exp_q.pop_front());
            m_prio = ~eo;
            m_busy = 1'b0;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input int n, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    int t;
    t = 0;
    if (n == 0) begin req_ctrl_0 = c; req_a_0 = a; req_b_0 = b; req_valid_0 = 1'b1; end
    else        begin req_ctrl_1 = c; req_a_1 = a; req_b_1 = b; req_valid_1 = 1'b1; end
    forever begin
      @(negedge clk);
      if ((n == 0) ? req_ready_0 : req_ready_1) break;
      t++;
      if (t > 300) begin
        check("accept_timeout", 64'(n), 64'(n + 100));
        break;
      end
    end
    @(posedge clk); #1;
    if (n == 0) req_valid_0 = 1'b0; else req_valid_1 = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    forever begin
      @(negedge clk); #1;
      if (!m_busy && exp_q.size() == 0) break;
      t++;
      if (t > 500) begin
        check("drain_timeout", 64'(exp_q.size()), 64'd0);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req_valid_0 = 1'b1;
    req_valid_1 = 1'b1;
    #1;
    check("rst_req_ready", {req_ready_1, req_ready_0}, 2'b00);
    check("rst_resp_valid", {resp_valid_1, resp_valid_0}, 2'b00);
    check("rst_resp_result", resp_result, 32'd0);
    check("rst_resp_flags", {resp_overflow, resp_zero}, 2'b00);
    check("rst_alu_control", alu_control, 4'd0);
    check("rst_alu_oper1", alu_oper1, 32'd0);
    check("rst_alu_oper2", alu_oper2, 32'd0);
    check("rst_state", dbg_state_o, 2'd0);
    req_valid_0 = 1'b0;
    req_valid_1 = 1'b0;
    exp_q.delete();
    m_busy = 1'b0;
    m_prio = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic rnd_driver(input int n, input int ops);
    for (int i = 0; i < ops; i++) begin
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      issue(n, 4'($urandom_range(0, 7)), rnd_val(), rnd_val());
    end
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rnd_on) begin
        resp_ready_0 = ($urandom_range(0, 3) != 0);
        resp_ready_1 = ($urandom_range(0, 3) != 0);
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin : main
    int t;
    req_valid_0 = 0; req_valid_1 = 0;
    req_ctrl_0 = 0; req_ctrl_1 = 0;
    req_a_0 = 0; req_b_0 = 0; req_a_1 = 0; req_b_1 = 0;
    resp_ready_0 = 1; resp_ready_1 = 1;
    apply_reset();

    // Single requester, 7+3.
    issue(0, 4'd0, 32'd7, 32'd3);
    wait_idle();
    check("r026_result", resp_result, 32'd10);
    check("r026_flags", {resp_overflow, resp_zero}, 2'b00);

    // Both valid on the first edge after reset.
    apply_reset();
    grant_log.delete();
    fork
      issue(0, 4'd0, 32'd1, 32'd1);
      issue(1, 4'd0, 32'd2, 32'd3);
    join
    wait_idle();
    check("r027_order_len", 64'(grant_log.size()), 64'd2);
    if (grant_log.size() == 2) begin
      check("r027_first", 64'(grant_log[0]), 64'd0);
      check("r027_second", 64'(grant_log[1]), 64'd1);
    end
    check("r027_last_result", resp_result, 32'd5);

    // Both continuously valid, four operations.
    grant_log.delete();
    fork
      begin
        issue(0, 4'($urandom_range(0, 7)), rnd_val(), rnd_val());
        issue(0, 4'($urandom_range(0, 7)), rnd_val(), rnd_val());
      end
      begin
        issue(1, 4'($urandom_range(0, 7)), rnd_val(), rnd_val());
        issue(1, 4'($urandom_range(0, 7)), rnd_val(), rnd_val());
      end
    join
    wait_idle();
    check("r028_order_len", 64'(grant_log.size()), 64'd4);
    if (grant_log.size() == 4)
      for (int i = 0; i < 4; i++) check("r028_order", 64'(grant_log[i]), 64'(i % 2));

    // Response back-pressure for five cycles with a competing request.
    resp_ready_0 = 1'b0;
    issue(0, 4'd0, 32'd3, 32'd3);
    fork
      begin
        t = 0;
        forever begin
          @(negedge clk);
          if (resp_valid_0 || t > 20) break;
          t++;
        end
        for (int i = 0; i < 5; i++) begin
          if (i > 0) @(negedge clk);
          check("r029_hold_valid", resp_valid_0, 1'b1);
          check("r029_hold_result", resp_result, 32'd6);
          check("r029_hold_zero", resp_zero, 1'b0);
        end
        @(posedge clk); #1;
        resp_ready_0 = 1'b1;
      end
      issue(1, 4'd1, 32'd9, 32'd4);
    join
    wait_idle();

    // Signed overflow boundary.
    issue(0, 4'd0, 32'h7FFF_FFFF, 32'd1);
    wait_idle();
    check("r030_overflow", resp_overflow, 1'b1);
    check("r030_result", resp_result, 32'h8000_0000);

    // Reset mid-EXEC: no response, priority back to requester 0.
    issue(0, 4'd0, 32'd5, 32'd6);
    #2;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("r031_no_resp", {resp_valid_1, resp_valid_0}, 2'b00);
    end
    @(posedge clk); #1;
    grant_log.delete();
    fork
      issue(0, 4'd2, rnd_val(), rnd_val());
      issue(1, 4'd3, rnd_val(), rnd_val());
    join
    wait_idle();
    if (grant_log.size() != 0) check("r031_first_grant", 64'(grant_log[0]), 64'd0);
    else check("r031_first_grant", 64'd99, 64'd0);

    // Randomized traffic with random response back-pressure.
    rnd_on = 1'b1;
    fork
      rnd_driver(0, 30);
      rnd_driver(1, 30);
    join
    rnd_on = 1'b0;
    resp_ready_0 = 1'b1;
    resp_ready_1 = 1'b1;
    wait_idle();
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter ALU_LAT, default 1: cycles from stable ALU operands to a valid alu_result, alu_overflow and alu_zero (range 1-15).
REQ-002 clk  input  1  Single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  Reset, asynchronous, active-low.
REQ-004 req_valid_0 / req_valid_1  input  1  Requester n has an operation pending.
REQ-005 req_ready_0 / req_ready_1  output  1  Requester n operation accepted this cycle.
REQ-006 req_ctrl_0 / req_ctrl_1  input  4  ALU control code from requester n.
REQ-007 req_a_0, req_b_0 / req_a_1, req_b_1  input  32  Operands 1 and 2 from requester n.
REQ-008 resp_valid_0 / resp_valid_1  output  1  Result for requester n is held.
REQ-009 resp_ready_0 / resp_ready_1  input  1  Requester n takes the result.
REQ-010 resp_result  output  32; resp_overflow, resp_zero  output  1 each  Captured ALU outputs, shared by both requesters.
REQ-011 alu_control  output  4; alu_oper1, alu_oper2  output  32  Registered drive to the shared ALU.
REQ-012 alu_result  input  32; alu_overflow, alu_zero  input  1 each  ALU outputs.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, EXEC and RESP.
REQ-014 IDLE: with one req_valid high, grant that requester; with both high, grant the requester selected by the priority pointer prio (0 or 1).
REQ-015 req_ready_n SHALL be combinational: high only in IDLE while req_valid_n is high and n is granted; at most one req_ready is high in any cycle.
REQ-016 Accept edge (IDLE, req_valid_n and req_ready_n high): load alu_control, alu_oper1 and alu_oper2 from requester n; record the owner (owner=n); go to EXEC; load the latency counter with ALU_LAT-1.
REQ-017 EXEC: alu_* outputs SHALL hold constant; the counter decrements each cycle; in the cycle the counter reads 0, capture alu_result, alu_overflow and alu_zero into the resp_* registers and go to RESP.
REQ-018 RESP: resp_valid_owner is high and the other resp_valid is low; resp_* SHALL hold stable until the owner's resp_ready is high, then return to IDLE.
REQ-019 On leaving RESP, prio SHALL become the non-owner (round-robin); prio is unchanged in all other cycles.
REQ-020 With ALU_LAT=1: accept in cycle C0, EXEC in C1, resp_valid high in C2; minimum issue interval ALU_LAT+2 cycles.
REQ-021 The block SHALL NOT decode or modify the ALU control code or operands; the 32-bit values pass through unchanged.
REQ-022 In IDLE, a requester that drops req_valid before acceptance is not granted; the arbiter does not act on the dropped request.
REQ-023 resp_ready_n while resp_valid_n is low SHALL be ignored.

Reset
REQ-024 rst_n low SHALL immediately force: state IDLE, prio=0, owner=0, counter=0, and all outputs 0 (req_ready_*, resp_valid_*, resp_result, resp_overflow, resp_zero, alu_control, alu_oper1, alu_oper2).
REQ-025 Reset in EXEC or RESP SHALL abandon the operation with no response; after rst_n rises, the first edge behaves as IDLE with prio=0.

Verification
REQ-026 Requester 0 only, ctrl=0, a=7, b=3, ALU_LAT=1 -> req_ready_0 in C0, resp_valid_0 in C2, resp_result=10, resp_zero=0, resp_overflow=0.
REQ-027 Both requesters valid on the first IDLE cycle after reset (r0: 1+1, r1: 2+3) -> r0 is served first with result 2, then r1 with result 5; req_ready is never high for both in one cycle.
REQ-028 Both requesters held continuously valid for 4 operations -> grant order 0,1,0,1.
REQ-029 Requester 0 sends 3+3 with resp_ready_0 held low for 5 cycles -> resp_valid_0 and resp_result=6 (resp_zero=0) held for all 5 cycles; no new accept until resp_ready_0 rises.
REQ-030 Requester 0 sends 0x7FFFFFFF+1, ctrl=0 -> resp_overflow=1, resp_result=0x80000000.
REQ-031 rst_n pulsed low during EXEC -> all outputs 0 asynchronously, no resp_valid afterwards, next accept goes to requester 0 when both requesters are valid.
